// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the zero-register index and the MEM-stage
// FSM state encoding used by the MEM stage, write-back and the register file.
package cpu_pkg;

    localparam int XLEN    = 64;
    localparam int REGW    = 5;
    localparam int XZR_IDX = 31;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // A doubleword access is legal only on an 8-byte boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[2:0] != 3'b000;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Writes to the zero register never reach the register file,
// so RegWrite is masked here for every source (ALU, load, fault).
module mem_wb_reg #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int REGW = cpu_pkg::REGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_valid,
    input  logic [REGW-1:0] i_reg,
    input  logic [XLEN-1:0] i_loaded,
    input  logic [XLEN-1:0] i_result,
    input  logic            i_mem_to_reg,
    input  logic            i_reg_write,
    output logic            o_valid,
    output logic [REGW-1:0] o_reg,
    output logic [XLEN-1:0] o_loaded,
    output logic [XLEN-1:0] o_result,
    output logic            o_mem_to_reg,
    output logic            o_reg_write
);
    import cpu_pkg::*;

    logic            r_valid;
    logic [REGW-1:0] r_reg;
    logic [XLEN-1:0] r_loaded;
    logic [XLEN-1:0] r_result;
    logic            r_mem_to_reg;
    logic            r_reg_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_reg        <= '0;
            r_loaded     <= '0;
            r_result     <= '0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
        end else if (i_load) begin
            r_valid      <= i_valid;
            r_reg        <= i_reg;
            r_loaded     <= i_loaded;
            r_result     <= i_result;
            r_mem_to_reg <= i_mem_to_reg;
            r_reg_write  <= i_reg_write && (i_reg != REGW'(XZR_IDX));
        end
    end

    assign o_valid      = r_valid;
    assign o_reg        = r_reg;
    assign o_loaded     = r_loaded;
    assign o_result     = r_result;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_reg_write  = r_reg_write;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory request at a time over req/ack, stalls
// execute while it is outstanding, and feeds the MEM/WB register.
module mem_access_stage #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int REGW = cpu_pkg::REGW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [XLEN-1:0]     ex_result,
    input  logic [XLEN-1:0]     ex_store_data,
    input  logic [REGW-1:0]     ex_reg,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic                ex_mem_to_reg,
    input  logic                ex_reg_write,
    output logic                mem_stall,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic [XLEN-1:0]     dmem_rdata,
    input  logic                dmem_ack,
    output logic                mem_fault,
    output logic                wb_valid,
    output logic [REGW-1:0]     Reg,
    output logic [XLEN-1:0]     loadedData,
    output logic [XLEN-1:0]     Results,
    output logic                MemToReg,
    output logic                RegWrite,
    output cpu_pkg::mem_state_t dbg_state
);
    import cpu_pkg::*;

    // Handshake: dmem_req stays high with stable we/addr/wdata until the cycle dmem_ack
    // is seen high; that cycle completes the access. dmem_ack outside WAIT has no effect.

    mem_state_t      r_state;
    mem_state_t      w_state_nxt;
    logic            r_req_we;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_req_wdata;
    logic [REGW-1:0] r_req_reg;
    logic            r_req_mem_to_reg;
    logic            r_req_reg_write;
    logic            r_fault;

    logic            w_idle;
    logic            w_mem_op;
    logic            w_illegal;
    logic            w_start;
    logic            w_fault;

    logic            w_wb_load;
    logic            w_wb_valid;
    logic [REGW-1:0] w_wb_reg;
    logic [XLEN-1:0] w_wb_loaded;
    logic [XLEN-1:0] w_wb_result;
    logic            w_wb_mem_to_reg;
    logic            w_wb_reg_write;

    assign w_idle    = (r_state == IDLE);
    assign w_mem_op  = ex_mem_read | ex_mem_write;
    assign w_illegal = w_mem_op & ((ex_mem_read & ex_mem_write) | is_misaligned(ex_result));
    assign w_start   = w_idle & ex_valid & w_mem_op & ~w_illegal;
    assign w_fault   = w_idle & ex_valid & w_illegal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)  w_state_nxt = WAIT;
            WAIT:    if (dmem_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_fault          <= 1'b0;
            r_req_we         <= 1'b0;
            r_req_addr       <= '0;
            r_req_wdata      <= '0;
            r_req_reg        <= '0;
            r_req_mem_to_reg <= 1'b0;
            r_req_reg_write  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fault <= w_fault;
            if (w_start) begin
                r_req_we         <= ex_mem_write;
                r_req_addr       <= ex_result;
                r_req_wdata      <= ex_store_data;
                r_req_reg        <= ex_reg;
                r_req_mem_to_reg <= ex_mem_to_reg;
                r_req_reg_write  <= ex_reg_write;
            end
        end
    end

    // MEM/WB loads every IDLE cycle (instruction, fault or bubble) and on the completing
    // ack; while waiting it holds the bubble written when the request was accepted.
    always_comb begin
        w_wb_load       = w_idle | dmem_ack;
        w_wb_valid      = 1'b0;
        w_wb_reg        = '0;
        w_wb_loaded     = '0;
        w_wb_result     = '0;
        w_wb_mem_to_reg = 1'b0;
        w_wb_reg_write  = 1'b0;
        if (!w_idle) begin
            w_wb_valid      = 1'b1;
            w_wb_reg        = r_req_reg;
            w_wb_loaded     = r_req_we ? '0 : dmem_rdata;
            w_wb_result     = r_req_addr;
            w_wb_mem_to_reg = r_req_mem_to_reg;
            w_wb_reg_write  = r_req_reg_write & ~r_req_we;
        end else if (ex_valid && !w_start) begin
            w_wb_valid      = 1'b1;
            w_wb_reg        = ex_reg;
            w_wb_result     = ex_result;
            w_wb_mem_to_reg = ex_mem_to_reg & ~w_fault;
            w_wb_reg_write  = ex_reg_write & ~w_fault;
        end
    end

    mem_wb_reg #(.XLEN(XLEN), .REGW(REGW)) u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_wb_load),
        .i_valid      (w_wb_valid),
        .i_reg        (w_wb_reg),
        .i_loaded     (w_wb_loaded),
        .i_result     (w_wb_result),
        .i_mem_to_reg (w_wb_mem_to_reg),
        .i_reg_write  (w_wb_reg_write),
        .o_valid      (wb_valid),
        .o_reg        (Reg),
        .o_loaded     (loadedData),
        .o_result     (Results),
        .o_mem_to_reg (MemToReg),
        .o_reg_write  (RegWrite)
    );

    assign mem_stall  = ~w_idle;
    assign dmem_req   = ~w_idle;
    assign dmem_we    = ~w_idle & r_req_we;
    assign dmem_addr  = w_idle ? '0 : r_req_addr;
    assign dmem_wdata = w_idle ? '0 : r_req_wdata;
    assign mem_fault  = r_fault;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: the driver pushes expected MEM/WB entries into a
// queue, a negedge monitor pops and compares whenever wb_valid is high.
module tb_mem_access_stage;
    import cpu_pkg::*;

    localparam int EW = 5 + 64 + 64 + 2;

    logic            clk;
    logic            rst;
    logic            ex_valid;
    logic [63:0]     ex_result;
    logic [63:0]     ex_store_data;
    logic [4:0]      ex_reg;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_reg_write;
    logic            mem_stall;
    logic            dmem_req;
    logic            dmem_we;
    logic [63:0]     dmem_addr;
    logic [63:0]     dmem_wdata;
    logic [63:0]     dmem_rdata;
    logic            dmem_ack;
    logic            mem_fault;
    logic            wb_valid;
    logic [4:0]      Reg;
    logic [63:0]     loadedData;
    logic [63:0]     Results;
    logic            MemToReg;
    logic            RegWrite;
    mem_state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    mem_access_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_reg(ex_reg), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .mem_stall(mem_stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_fault(mem_fault),
        .wb_valid(wb_valid), .Reg(Reg), .loadedData(loadedData), .Results(Results),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] pack(input logic [4:0] r, input logic [63:0] ld,
                                           input logic [63:0] res, input logic mtr,
                                           input logic rw);
        return {r, ld, res, mtr, rw};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_result = '0; ex_store_data = '0; ex_reg = '0;
        ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0; ex_reg_write = 0;
    endtask

    task automatic issue(input logic [63:0] res, input logic [63:0] sd, input logic [4:0] r,
                         input logic rd, input logic wr, input logic mtr, input logic rw);
        ex_valid = 1; ex_result = res; ex_store_data = sd; ex_reg = r;
        ex_mem_read = rd; ex_mem_write = wr; ex_mem_to_reg = mtr; ex_reg_write = rw;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got entry reg=%0d res=%h, required none", Reg, Results);
            end else begin
                logic [EW-1:0] e;
                logic [EW-1:0] a;
                e = exp_q.pop_front();
                a = pack(Reg, loadedData, Results, MemToReg, RegWrite);
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL wb_entry: got %h, required %h", a, e);
                end
            end
        end
    end

    initial begin
        rst = 1; dmem_ack = 0; dmem_rdata = 64'h0123_4567_89ab_cdef;
        issue(64'hffff_ffff_ffff_fff3, 64'h5555, 5'd12, 1, 1, 1, 1);
        tick(); tick();
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_req", 64'(dmem_req), 0);
        check("rst_we", 64'(dmem_we), 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_stall", 64'(mem_stall), 0);
        check("rst_fault", 64'(mem_fault), 0);
        check("rst_wb", {wb_valid, Reg, MemToReg, RegWrite}, 0);
        check("rst_loaded", loadedData, 0);
        check("rst_results", Results, 0);
        clear_ex(); dmem_rdata = '0;
        @(negedge clk); rst = 0;
        tick();

        // ALU pass-through, then a second back-to-back, then a bubble
        issue(64'h1234, 0, 5'd7, 0, 0, 0, 1);
        exp_q.push_back(pack(5'd7, 0, 64'h1234, 0, 1));
        tick();
        check("alu_stall", 64'(mem_stall), 0);
        check("alu_valid", 64'(wb_valid), 1);
        issue(64'h0bad_cafe, 0, 5'd3, 0, 0, 1, 1);
        exp_q.push_back(pack(5'd3, 0, 64'h0bad_cafe, 1, 1));
        tick();
        check("alu2_valid", 64'(wb_valid), 1);
        clear_ex();
        tick();
        check("bubble_valid", 64'(wb_valid), 0);
        check("bubble_rw", 64'(RegWrite), 0);

        // Load, ack in the third request cycle; ex_* garbage while waiting is ignored
        issue(64'h100, 0, 5'd5, 1, 0, 1, 1);
        tick();
        issue(64'h40, 64'h77, 5'd9, 0, 1, 0, 0);
        check("ld_req1", 64'(dmem_req), 1);
        check("ld_we", 64'(dmem_we), 0);
        check("ld_addr", dmem_addr, 64'h100);
        check("ld_stall1", 64'(mem_stall), 1);
        check("ld_wb_bubble", 64'(wb_valid), 0);
        tick();
        check("ld_req2", 64'(dmem_req), 1);
        check("ld_stall2", 64'(mem_stall), 1);
        check("ld_addr_hold", dmem_addr, 64'h100);
        tick();
        clear_ex();
        check("ld_req3", 64'(dmem_req), 1);
        check("ld_stall3", 64'(mem_stall), 1);
        dmem_ack = 1; dmem_rdata = 64'hDEAD_BEEF;
        exp_q.push_back(pack(5'd5, 64'hDEAD_BEEF, 64'h100, 1, 1));
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        check("ld_done_req", 64'(dmem_req), 0);
        check("ld_done_stall", 64'(mem_stall), 0);
        check("ld_done_valid", 64'(wb_valid), 1);

        // Store with same-cycle ack
        issue(64'h208, 64'hAA, 5'd9, 0, 1, 0, 1);
        tick();
        clear_ex();
        check("st_req", 64'(dmem_req), 1);
        check("st_we", 64'(dmem_we), 1);
        check("st_addr", dmem_addr, 64'h208);
        check("st_wdata", dmem_wdata, 64'hAA);
        dmem_ack = 1; dmem_rdata = 64'hFFFF_0000;
        exp_q.push_back(pack(5'd9, 0, 64'h208, 0, 0));
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        check("st_done_req", 64'(dmem_req), 0);
        check("st_done_rw", 64'(RegWrite), 0);

        // Misaligned load
        issue(64'h103, 0, 5'd4, 1, 0, 1, 1);
        exp_q.push_back(pack(5'd4, 0, 64'h103, 0, 0));
        tick();
        clear_ex();
        check("mis_req", 64'(dmem_req), 0);
        check("mis_fault", 64'(mem_fault), 1);
        check("mis_stall", 64'(mem_stall), 0);
        tick();
        check("mis_fault_pulse", 64'(mem_fault), 0);

        // Read and write both set, aligned
        issue(64'h200, 64'h11, 5'd6, 1, 1, 1, 1);
        exp_q.push_back(pack(5'd6, 0, 64'h200, 0, 0));
        tick();
        clear_ex();
        check("rw_req", 64'(dmem_req), 0);
        check("rw_fault", 64'(mem_fault), 1);
        check("rw_rw", 64'(RegWrite), 0);
        tick();

        // XZR destination
        issue(64'h55, 0, 5'd31, 0, 0, 0, 1);
        exp_q.push_back(pack(5'd31, 0, 64'h55, 0, 0));
        tick();
        clear_ex();
        check("xzr_rw", 64'(RegWrite), 0);

        // Ack while idle is ignored
        dmem_ack = 1; dmem_rdata = 64'h9999;
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        check("idle_ack_state", 64'(dbg_state), 64'(IDLE));
        check("idle_ack_valid", 64'(wb_valid), 0);

        // Reset during WAIT, then a late ack
        issue(64'h300, 0, 5'd8, 1, 0, 1, 1);
        tick();
        clear_ex();
        check("rw_wait_req", 64'(dmem_req), 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("rstw_req", 64'(dmem_req), 0);
        check("rstw_valid", 64'(wb_valid), 0);
        check("rstw_stall", 64'(mem_stall), 0);
        dmem_ack = 1; dmem_rdata = 64'h4444;
        tick();
        dmem_ack = 0;
        check("late_ack_valid", 64'(wb_valid), 0);
        check("late_ack_req", 64'(dmem_req), 0);
        check("late_ack_state", 64'(dbg_state), 64'(IDLE));
        tick(); tick();

        check("queue_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the 64-bit CPU. It sits between the execute stage and the write-back stage. It takes one instruction per cycle from execute, performs any data-memory load or store over a req/ack handshake, and stalls upstream while a memory access is outstanding. It then registers `Reg`, `loadedData`, `Results`, `MemToReg` and `RegWrite` into the MEM/WB register that write-back consumes.

## Interface
Parameters:
- `XLEN`, 64, data/address width
- `REGW`, 5, register index width

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ex_valid`  in  1  execute stage presents an instruction
- `ex_result`  in  XLEN  ALU result; memory address for loads/stores
- `ex_store_data`  in  XLEN  store data
- `ex_reg`  in  REGW  destination register
- `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_reg_write`  in  1 each  control bits
- `mem_stall`  out  1  upstream must hold its instruction
- `dmem_req`  out  1  memory request
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  XLEN  request address
- `dmem_wdata`  out  XLEN  store data
- `dmem_rdata`  in  XLEN  load data, valid with `dmem_ack`
- `dmem_ack`  in  1  access complete
- `mem_fault`  out  1  one-cycle pulse on illegal memory op
- `wb_valid`  out  1  MEM/WB register holds a real instruction
- `Reg`  out  REGW  destination register
- `loadedData`  out  XLEN  loaded data
- `Results`  out  XLEN  ALU result
- `MemToReg`  out  1  control bit to write-back
- `RegWrite`  out  1  control bit to write-back

## Operation
- **FSM states:**
  - `IDLE`: accepting instructions.
  - `WAIT`: request outstanding.
- **IDLE, `ex_valid` = 0:** next cycle `wb_valid` = 0 and `RegWrite` = 0 (bubble).
- **IDLE, `ex_valid`, no memory op:** next cycle `wb_valid` = 1, `Results` = `ex_result`, `Reg`/`MemToReg`/`RegWrite` copied, `loadedData` = 0.
- **IDLE, `ex_valid`, exactly one of read/write, `ex_result[2:0]` = 0:**
  - Latch address, store data, reg and control bits.
  - Go to `WAIT`; bubble into MEM/WB this cycle.
- **IDLE, `ex_valid`, illegal memory op** (misaligned, i.e. `ex_result[2:0]` ≠ 0, or read and write both set):
  - No memory access.
  - `mem_fault` pulses next cycle.
  - MEM/WB gets `wb_valid` = 1 with `RegWrite` = 0 and `MemToReg` = 0.
- **WAIT:**
  - Drive `dmem_req` = 1 with `dmem_we`, `dmem_addr` and `dmem_wdata` taken from the latched request; hold them stable until `dmem_ack`.
  - Ignore all `ex_*` inputs.
- **WAIT, `dmem_ack` = 1:**
  - Register the request into MEM/WB with `wb_valid` = 1.
  - Load: `loadedData` = `dmem_rdata`. Store: `loadedData` = 0 and `RegWrite` forced to 0.
  - Return to `IDLE`.
- **XZR:** `Reg` = 31 always forces `RegWrite` = 0.
- **`mem_stall`** = (state == `WAIT`), combinational from state only.
- **`dmem_ack` in IDLE:** ignored.

## Timing
- **Reset values:** state `IDLE`; all outputs 0, including `dmem_*`, `mem_stall`, `mem_fault`, `wb_valid`, `Reg`, `loadedData`, `Results`, `MemToReg`, `RegWrite`.
- **Non-memory instruction:** latency 1. Accepted at T, visible in MEM/WB at T+1.
- **Memory instruction:**
  - Accepted at T; `dmem_req` high from T+1.
  - Ack at T+k (k ≥ 1); MEM/WB valid at T+k+1.
  - `mem_stall` high T+1 … T+k.
  - Next instruction accepted at T+k+1.
- **Ack timing:** ack in the same cycle `dmem_req` first rises (k = 1) is legal.
- **Reset mid-WAIT:** `dmem_req` is 0 the cycle after `rst`. The pending access is dropped and produces no MEM/WB entry. A late ack is ignored.
- **Throughput:** one instruction per cycle with no memory ops.

## Structure
- **Shared package `cpu_pkg`:** `XLEN`, `REGW`, `XZR_IDX` = 31, and the enum `mem_state_t` {`IDLE`, `WAIT`}. `WriteBack` and the register file also use it.
- **Sub-module `mem_wb_reg`:** the MEM/WB pipeline register, with load-enable and the XZR `RegWrite` masking.
- **Top level:** the FSM, the request latch and fault detection.

## Test plan
- **Reset:**
  - Stimulus: hold `rst` 2 cycles with garbage on `ex_*`.
  - Required: every output 0; state `IDLE`.
- **ALU pass-through:**
  - Stimulus: `ex_result` = 0x1234, `ex_reg` = 7, `ex_reg_write` = 1, no memory op.
  - Required: next cycle `wb_valid` = 1, `Results` = 0x1234, `Reg` = 7, `RegWrite` = 1, `mem_stall` = 0.
- **Load with 3-cycle ack:**
  - Stimulus: address 0x100, reg 5, `dmem_ack` at T+3 with `dmem_rdata` = 0xDEADBEEF.
  - Required: `dmem_req` high T+1..T+3, `mem_stall` high T+1..T+3, `loadedData` = 0xDEADBEEF with `MemToReg` = 1 at T+4.
- **Store with k = 1:**
  - Stimulus: address 0x208, data 0xAA.
  - Required: `dmem_we` = 1, `dmem_wdata` = 0xAA, MEM/WB `RegWrite` = 0 at T+2.
- **Faults:**
  - Stimulus: load at address 0x103; separately, read and write both set.
  - Required in both cases: no `dmem_req`, `mem_fault` pulse, `RegWrite` = 0.
  - Stimulus: ALU op with `ex_reg` = 31, `ex_reg_write` = 1.
  - Required: `RegWrite` = 0.
- **Reset in WAIT:**
  - Stimulus: assert `rst` at T+2 of a load, then send a late `dmem_ack`.
  - Required: `dmem_req` = 0, `wb_valid` = 0, no MEM/WB update.
